// File: rtl/ocm_stream_engine_pkg.sv
// rtl/ocm_stream_engine_pkg.sv - shared state encoding, transform modes and read-latency limits
package ocm_stream_engine_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_TERN = 2'd1;
    localparam logic [1:0] MODE_RELU = 2'd2;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/ocm_stream_engine_elem_transform.sv
// rtl/ocm_stream_engine_elem_transform.sv - registered per-element transform (pass / ternary / ReLU)
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   x            signed input element (IW bits)
//   mode         transform select (MODE_PASS, MODE_TERN, MODE_RELU; 3 acts as pass)
//   threshold    unsigned ternary threshold (IW bits)
//   in_valid     x is valid this cycle
//   y            registered result (OW bits), one cycle after in_valid
//   out_valid    y is valid this cycle
module elem_transform
    import ocm_stream_engine_pkg::*;
#(
    parameter int IW = 8,
    parameter int OW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] x,
    input  logic [1:0]    mode,
    input  logic [IW-1:0] threshold,
    input  logic          in_valid,
    output logic [OW-1:0] y,
    output logic          out_valid
);

    logic signed [IW-1:0] x_s;
    logic signed [IW:0]   x_ext;
    logic signed [IW:0]   thr_pos;
    logic signed [IW:0]   thr_neg;
    logic [OW-1:0]        y_d;

    // Comparisons run one bit wider than the data so that -threshold is
    // representable even when threshold is at its maximum.
    always_comb begin
        x_s     = $signed(x);
        x_ext   = $signed({x[IW-1], x});
        thr_pos = $signed({1'b0, threshold});
        thr_neg = -thr_pos;
        y_d     = OW'(x_s);
        case (mode)
            MODE_TERN: begin
                if (x_ext > thr_pos) begin
                    y_d = OW'(1);
                end else if (x_ext < thr_neg) begin
                    y_d = '1;
                end else begin
                    y_d = '0;
                end
            end
            MODE_RELU: begin
                y_d = x[IW-1] ? '0 : OW'(x_s);
            end
            default: begin
                y_d = OW'(x_s);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y <= y_d;
            end
        end
    end

endmodule

// File: rtl/ocm_stream_engine.sv
// rtl/ocm_stream_engine.sv - streams LENGTH words OCM0 -> transform -> OCM1 with busy/done/count
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle start request, honoured only in IDLE
//   length, mode,         job configuration, latched when start is accepted
//   threshold, rd_base,
//   wr_base
//   ocm0_*                OCM0 read port (address, chipselect, clock enable, read data)
//   ocm1_*                OCM1 write port (address, chipselect, clock enable, write, write data)
//   busy, done, count     status: running, completion pulse, writes completed
module ocm_stream_engine
    import ocm_stream_engine_pkg::*;
#(
    parameter int AW     = 17,
    parameter int IW     = 8,
    parameter int OW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   length,
    input  logic [1:0]    mode,
    input  logic [IW-1:0] threshold,
    input  logic [AW-1:0] rd_base,
    input  logic [AW-1:0] wr_base,
    output logic [AW-1:0] ocm0_addr,
    output logic          ocm0_chip,
    output logic          ocm0_clk_enab,
    input  logic [IW-1:0] ocm0_readdata,
    output logic [AW-1:0] ocm1_addr,
    output logic          ocm1_chip,
    output logic          ocm1_clk_enab,
    output logic          ocm1_write,
    output logic [OW-1:0] ocm1_writedata,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("ocm_stream_engine: RD_LAT out of range");
    end

    localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

    state_t              state_q;
    state_t              state_d;
    logic [AW:0]         len_q;
    logic [AW:0]         len_sat;
    logic [1:0]          mode_q;
    logic [IW-1:0]       thr_q;
    logic [AW-1:0]       rd_base_q;
    logic [AW-1:0]       wr_base_q;
    logic [AW:0]         rd_idx_q;
    logic [AW-1:0]       wr_idx_q;
    logic [AW:0]         count_q;
    logic [RD_LAT-1:0]   vld_sr;
    logic                accept;
    logic                rd_fire;
    logic                wr_fire;
    logic [OW-1:0]       xf_y;

    assign len_sat = (length > LEN_MAX) ? LEN_MAX : length;
    assign accept  = (state_q == S_IDLE) && start;
    assign rd_fire = (state_q == S_READ);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (rd_idx_q == len_q - 1'b1) begin
                    state_d = S_DRAIN;
                end
            end
            // Reads are back to back, so the final write always lands in
            // DRAIN; finishing on the write count keeps this independent of RD_LAT.
            S_DRAIN: begin
                if (wr_fire && (count_q + 1'b1 == len_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            mode_q    <= MODE_PASS;
            thr_q     <= '0;
            rd_base_q <= '0;
            wr_base_q <= '0;
            rd_idx_q  <= '0;
            wr_idx_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                len_q     <= len_sat;
                mode_q    <= mode;
                thr_q     <= threshold;
                rd_base_q <= rd_base;
                wr_base_q <= wr_base;
                rd_idx_q  <= '0;
                wr_idx_q  <= '0;
                count_q   <= '0;
            end else begin
                if (rd_fire) begin
                    rd_idx_q <= rd_idx_q + 1'b1;
                end
                if (wr_fire) begin
                    wr_idx_q <= wr_idx_q + 1'b1;
                    count_q  <= count_q + 1'b1;
                end
            end
        end
    end

    // Bit k is set when a read issued k+1 cycles ago is outstanding; the top
    // bit lines up with that read's data on ocm0_readdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= rd_fire;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    elem_transform #(
        .IW (IW),
        .OW (OW)
    ) u_xform (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (ocm0_readdata),
        .mode      (mode_q),
        .threshold (thr_q),
        .in_valid  (vld_sr[RD_LAT-1]),
        .y         (xf_y),
        .out_valid (wr_fire)
    );

    assign ocm0_addr      = rd_base_q + rd_idx_q[AW-1:0];
    assign ocm0_chip      = rd_fire;
    assign ocm0_clk_enab  = 1'b1;
    assign ocm1_addr      = wr_base_q + wr_idx_q;
    assign ocm1_write     = wr_fire;
    assign ocm1_chip      = wr_fire;
    assign ocm1_clk_enab  = 1'b1;
    assign ocm1_writedata = xf_y;
    assign busy           = (state_q == S_READ) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign count          = count_q;

endmodule

// File: tb/tb_ocm_stream_engine.sv
// tb/tb_ocm_stream_engine.sv - self-checking bench for ocm_stream_engine
module tb_ocm_stream_engine;

    localparam int AW     = 17;
    localparam int IW     = 8;
    localparam int OW     = 8;
    localparam int RD_LAT = 1;
    localparam int AMASK  = (1 << AW) - 1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW:0]   length;
    logic [1:0]    mode;
    logic [IW-1:0] threshold;
    logic [AW-1:0] rd_base;
    logic [AW-1:0] wr_base;
    logic [AW-1:0] ocm0_addr;
    logic          ocm0_chip;
    logic          ocm0_clk_enab;
    logic [IW-1:0] ocm0_readdata;
    logic [AW-1:0] ocm1_addr;
    logic          ocm1_chip;
    logic          ocm1_clk_enab;
    logic          ocm1_write;
    logic [OW-1:0] ocm1_writedata;
    logic          busy;
    logic          done;
    logic [AW:0]   count;

    ocm_stream_engine #(
        .AW     (AW),
        .IW     (IW),
        .OW     (OW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .length         (length),
        .mode           (mode),
        .threshold      (threshold),
        .rd_base        (rd_base),
        .wr_base        (wr_base),
        .ocm0_addr      (ocm0_addr),
        .ocm0_chip      (ocm0_chip),
        .ocm0_clk_enab  (ocm0_clk_enab),
        .ocm0_readdata  (ocm0_readdata),
        .ocm1_addr      (ocm1_addr),
        .ocm1_chip      (ocm1_chip),
        .ocm1_clk_enab  (ocm1_clk_enab),
        .ocm1_write     (ocm1_write),
        .ocm1_writedata (ocm1_writedata),
        .busy           (busy),
        .done           (done),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // OCM0 model with a one-cycle registered read
    logic [IW-1:0] ram0 [0:(1<<AW)-1];
    always @(posedge clk) ocm0_readdata <= ram0[ocm0_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int t0 = 0;
    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_cyc_q[$];
    int rd_addr_q[$];
    int done_n = 0;
    int done_cyc = -1;
    int chip_mismatch = 0;
    logic busy_hist [64];

    always @(negedge clk) begin
        if (ocm1_write) begin
            wr_addr_q.push_back(int'(ocm1_addr));
            wr_data_q.push_back(int'(ocm1_writedata));
            wr_cyc_q.push_back(cyc - t0);
        end
        if (ocm1_chip !== ocm1_write) chip_mismatch++;
        if (ocm0_chip) rd_addr_q.push_back(int'(ocm0_addr));
        if (done) begin
            done_n++;
            done_cyc = cyc - t0;
        end
        if (cyc - t0 >= 0 && cyc - t0 < 64) busy_hist[cyc - t0] = busy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_job(input int len, input logic [1:0] md, input logic [7:0] thr,
                             input int rdb, input int wrb);
        @(posedge clk);
        #1;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        rd_addr_q.delete();
        done_n   = 0;
        done_cyc = -1;
        for (int i = 0; i < 64; i++) busy_hist[i] = 1'bx;
        t0        = cyc;
        length    = (AW+1)'(len);
        mode      = md;
        threshold = thr;
        rd_base   = AW'(rdb);
        wr_base   = AW'(wrb);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int k;
        k = 0;
        while (done_n == 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (done_n == 0) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, bound);
        end
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] thr;
        int         len;
        logic [7:0] din  [5];
        logic [7:0] dexp [5];
    } vec_t;

    vec_t vecs [7];

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        length    = '0;
        mode      = '0;
        threshold = '0;
        rd_base   = '0;
        wr_base   = '0;

        // passthrough (plan item 1)
        vecs[0].mode = 2'd0; vecs[0].thr = 8'd0;   vecs[0].len = 4;
        vecs[0].din  = '{8'd5, 8'hFD, 8'd0, 8'd127, 8'd0};
        vecs[0].dexp = '{8'd5, 8'hFD, 8'd0, 8'd127, 8'd0};
        // ternary, threshold 10: strict compare at both edges
        vecs[1].mode = 2'd1; vecs[1].thr = 8'd10;  vecs[1].len = 5;
        vecs[1].din  = '{8'd11, 8'd10, 8'hF6, 8'hF5, 8'd0};
        vecs[1].dexp = '{8'd1, 8'd0, 8'd0, 8'hFF, 8'd0};
        // ReLU
        vecs[2].mode = 2'd2; vecs[2].thr = 8'd0;   vecs[2].len = 5;
        vecs[2].din  = '{8'h80, 8'hFF, 8'd0, 8'd1, 8'd127};
        vecs[2].dexp = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd127};
        // reserved mode 3 behaves as passthrough
        vecs[3].mode = 2'd3; vecs[3].thr = 8'd0;   vecs[3].len = 5;
        vecs[3].din  = '{8'h80, 8'hFF, 8'd0, 8'd1, 8'd127};
        vecs[3].dexp = '{8'h80, 8'hFF, 8'd0, 8'd1, 8'd127};
        // ternary, threshold 0
        vecs[4].mode = 2'd1; vecs[4].thr = 8'd0;   vecs[4].len = 5;
        vecs[4].din  = '{8'd1, 8'd0, 8'hFF, 8'd127, 8'h80};
        vecs[4].dexp = '{8'd1, 8'd0, 8'hFF, 8'd1, 8'hFF};
        // ternary, threshold 255: -255 needs the widened compare, all results 0
        vecs[5].mode = 2'd1; vecs[5].thr = 8'd255; vecs[5].len = 3;
        vecs[5].din  = '{8'h80, 8'd127, 8'd0, 8'd0, 8'd0};
        vecs[5].dexp = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        // ternary, threshold 127
        vecs[6].mode = 2'd1; vecs[6].thr = 8'd127; vecs[6].len = 3;
        vecs[6].din  = '{8'd127, 8'h81, 8'h80, 8'd0, 8'd0};
        vecs[6].dexp = '{8'd0, 8'd0, 8'hFF, 8'd0, 8'd0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_ocm0_chip", ocm0_chip, 1'b0);
        check("rst_ocm1_write", ocm1_write, 1'b0);
        check("rst_ocm1_chip", ocm1_chip, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_count", count, 0);
        check("rst_ocm0_addr", ocm0_addr, 0);
        check("rst_ocm1_addr", ocm1_addr, 0);
        check("rst_writedata", ocm1_writedata, 0);
        check("rst_ocm0_clk_enab", ocm0_clk_enab, 1'b1);
        check("rst_ocm1_clk_enab", ocm1_clk_enab, 1'b1);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            int rdb;
            int wrb;
            rdb = 64 * k;
            wrb = 256 + 16 * k;
            for (int i = 0; i < 5; i++) ram0[AW'(rdb + i)] = vecs[k].din[i];
            start_job(vecs[k].len, vecs[k].mode, vecs[k].thr, rdb, wrb);
            wait_done($sformatf("vec%0d", k), 50);
            check($sformatf("vec%0d_nwrites", k), wr_data_q.size(), vecs[k].len);
            for (int i = 0; i < vecs[k].len && i < wr_data_q.size(); i++) begin
                check($sformatf("vec%0d_data%0d", k, i), wr_data_q[i], {24'd0, vecs[k].dexp[i]});
                check($sformatf("vec%0d_addr%0d", k, i), wr_addr_q[i], (wrb + i) & AMASK);
                check($sformatf("vec%0d_wcyc%0d", k, i), wr_cyc_q[i], 2 + RD_LAT + i);
            end
            check($sformatf("vec%0d_done_cyc", k), done_cyc, 2 + RD_LAT + vecs[k].len);
            check($sformatf("vec%0d_done_n", k), done_n, 1);
            check($sformatf("vec%0d_count", k), count, vecs[k].len);
            if (k == 0) begin
                check("vec0_busy_c0", busy_hist[0], 1'b0);
                check("vec0_busy_c1", busy_hist[1], 1'b1);
                check("vec0_busy_c6", busy_hist[6], 1'b1);
                check("vec0_busy_c7", busy_hist[7], 1'b0);
            end
        end

        // zero length: done at cycle 1, no memory traffic, count cleared
        start_job(0, 2'd0, 8'd0, 100, 200);
        wait_done("len0", 20);
        check("len0_done_cyc", done_cyc, 1);
        check("len0_reads", rd_addr_q.size(), 0);
        check("len0_writes", wr_data_q.size(), 0);
        check("len0_count", count, 0);
        check("len0_busy_c1", busy_hist[1], 1'b0);

        // address wrap on both ports, stray starts and config changes mid-run
        ram0[AW'(AMASK - 1)] = 8'hFB;
        ram0[AW'(AMASK)]     = 8'd3;
        ram0[AW'(0)]         = 8'hFF;
        ram0[AW'(1)]         = 8'd7;
        start_job(4, 2'd0, 8'd0, AMASK - 1, AMASK);
        start  = 1'b1;
        mode   = 2'd2;
        length = 2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("wrap", 50);
        repeat (10) @(negedge clk);
        check("wrap_done_n", done_n, 1);
        check("wrap_nreads", rd_addr_q.size(), 4);
        check("wrap_nwrites", wr_data_q.size(), 4);
        if (rd_addr_q.size() == 4) begin
            check("wrap_raddr0", rd_addr_q[0], AMASK - 1);
            check("wrap_raddr1", rd_addr_q[1], AMASK);
            check("wrap_raddr2", rd_addr_q[2], 0);
            check("wrap_raddr3", rd_addr_q[3], 1);
        end
        if (wr_data_q.size() == 4) begin
            check("wrap_waddr0", wr_addr_q[0], AMASK);
            check("wrap_waddr1", wr_addr_q[1], 0);
            check("wrap_data0", wr_data_q[0], 32'hFB);
            check("wrap_data2", wr_data_q[2], 32'hFF);
        end
        check("wrap_count", count, 4);
        check("ocm1_chip_eq_write", chip_mismatch, 0);

        // reset mid-run after two of eight writes
        for (int i = 0; i < 8; i++) ram0[AW'(512 + i)] = 8'(10 + i);
        start_job(8, 2'd0, 8'd0, 512, 768);
        begin
            int k;
            k = 0;
            while (wr_data_q.size() < 2 && k < 30) begin
                @(posedge clk); #1;
                k++;
            end
        end
        rst_n = 1'b0;
        #1;
        check("mrst_ocm1_write", ocm1_write, 1'b0);
        check("mrst_ocm0_chip", ocm0_chip, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", done, 1'b0);
        check("mrst_count", count, 0);
        check("mrst_ocm1_addr", ocm1_addr, 0);
        check("mrst_writedata", ocm1_writedata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("mrst_writes", wr_data_q.size(), 2);
        check("mrst_no_done", done_n, 0);

        start_job(3, 2'd0, 8'd0, 512, 768);
        wait_done("post_rst", 30);
        check("post_rst_count", count, 3);
        check("post_rst_nwrites", wr_data_q.size(), 3);
        if (wr_data_q.size() == 3) begin
            check("post_rst_data0", wr_data_q[0], 10);
            check("post_rst_data2", wr_data_q[2], 12);
            check("post_rst_addr2", wr_addr_q[2], 770);
        end
        check("post_rst_done_cyc", done_cyc, 2 + RD_LAT + 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
